// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the ARM byte-addressed data memory and its load formatter.
package arm_mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10,
      MEM_RSVD = 2'b11
   } mem_size_t;

   typedef enum logic {
      DMEM_CLEAR = 1'b0,
      DMEM_READY = 1'b1
   } dmem_state_t;

   localparam int LANES = 4;

   // Reserved size always faults; halfwords need addr[0]=0, words need addr[1:0]=0.
   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr);
      case (size)
         MEM_BYTE: return 1'b0;
         MEM_HALF: return addr[0];
         MEM_WORD: return |addr;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/arm_load_formatter.sv
// Selects the addressed byte/half/word from a 32-bit memory word and zero- or sign-extends it.
module arm_load_formatter
   import arm_mem_pkg::*;
(
   input  logic [31:0] i_Word,
   input  logic [1:0]  i_Lane,
   input  mem_size_t   i_Size,
   input  logic        i_Signed,
   output logic [31:0] o_Data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_Word[8*i_Lane +: 8];
   assign w_half = i_Lane[1] ? i_Word[31:16] : i_Word[15:0];

   // NOTE: o_Data gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_Data = '0;
      case (i_Size)
         MEM_BYTE: o_Data = {{24{i_Signed & w_byte[7]}}, w_byte};
         MEM_HALF: o_Data = {{16{i_Signed & w_half[15]}}, w_half};
         MEM_WORD: o_Data = i_Word;
         default:  o_Data = '0;
      endcase
   end

endmodule

// File: rtl/arm_byte_data_memory.sv
// Byte-addressed data memory with a post-reset clear sweep, lane-merged stores and formatted loads.
// Optional per-byte even parity is enabled with `define DMEM_PARITY_EN.
module arm_byte_data_memory
   import arm_mem_pkg::*;
#(
   parameter int BusWidth    = 32,
   parameter int DataMemSize = 64
) (
   input  logic                i_CLK,
   input  logic                i_RESET,
   input  logic                i_Write_Enable,
   input  logic [1:0]          i_Size,
   input  logic                i_Signed,
   input  logic [BusWidth-1:0] i_Address,
   input  logic [BusWidth-1:0] i_Write_Data,
   output logic [BusWidth-1:0] o_Read_Data,
   output logic                o_Busy,
   output logic                o_Align_Fault,
   output logic                o_Parity_Error
);

   localparam int AW = $clog2(DataMemSize);

   dmem_state_t         r_state, w_next_state;
   logic [AW-1:0]       r_clr_idx, w_next_clr_idx;
   logic [BusWidth-1:0] r_mem [DataMemSize];

   mem_size_t           w_size;
   logic [AW-1:0]       w_idx;
   logic [1:0]          w_lane;
   logic                w_ready, w_fault, w_store, w_load_ok;
   logic [LANES-1:0]    w_be;
   logic [31:0]         w_wdata, w_word, w_fmt;
   logic                w_unused_addr;

   assign w_size        = mem_size_t'(i_Size);
   assign w_idx         = i_Address[AW+1:2];
   assign w_lane        = i_Address[1:0];
   assign w_unused_addr = ^i_Address[BusWidth-1:AW+2];
   assign w_ready       = (r_state == DMEM_READY);
   assign w_fault       = w_ready && is_misaligned(w_size, w_lane);
   assign w_load_ok     = w_ready && !w_fault;
   assign w_store       = w_load_ok && i_Write_Enable && !i_RESET;
   assign w_word        = r_mem[w_idx];

   // Replicate store data across lanes so a byte-enable mask alone selects what lands.
   always_comb begin
      w_be    = '0;
      w_wdata = i_Write_Data;
      case (w_size)
         MEM_BYTE: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_Write_Data[7:0]}};
         end
         MEM_HALF: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_Write_Data[15:0]}};
         end
         MEM_WORD: w_be = 4'b1111;
         default:  w_be = '0;
      endcase
   end

   always_comb begin
      w_next_state   = r_state;
      w_next_clr_idx = r_clr_idx;
      case (r_state)
         DMEM_CLEAR: begin
            w_next_clr_idx = r_clr_idx + AW'(1);
            if (r_clr_idx == AW'(DataMemSize - 1))
               w_next_state = DMEM_READY;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         r_state   <= DMEM_CLEAR;
         r_clr_idx <= '0;
      end else begin
         r_state   <= w_next_state;
         r_clr_idx <= w_next_clr_idx;
      end
   end

   // NOTE: the array has no reset branch; it is zeroed one word per cycle by the clear sweep.
   always_ff @(posedge i_CLK) begin
      if (r_state == DMEM_CLEAR) begin
         r_mem[r_clr_idx] <= '0;
      end else if (w_store) begin
         for (int l = 0; l < LANES; l++)
            if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
   end

   arm_load_formatter u_fmt (
      .i_Word   (w_word),
      .i_Lane   (w_lane),
      .i_Size   (w_size),
      .i_Signed (i_Signed),
      .o_Data   (w_fmt)
   );

   assign o_Read_Data   = w_load_ok ? w_fmt : '0;
   assign o_Align_Fault = w_fault;
   assign o_Busy        = !w_ready;

`ifdef DMEM_PARITY_EN
   logic [LANES-1:0] r_par [DataMemSize];
   logic [LANES-1:0] w_par_new, w_par_cur;

   always_comb begin
      w_par_new = '0;
      w_par_cur = '0;
      for (int l = 0; l < LANES; l++) begin
         w_par_new[l] = ^w_wdata[8*l +: 8];
         w_par_cur[l] = ^w_word[8*l +: 8];
      end
   end

   always_ff @(posedge i_CLK) begin
      if (r_state == DMEM_CLEAR) begin
         r_par[r_clr_idx] <= '0;
      end else if (w_store) begin
         for (int l = 0; l < LANES; l++)
            if (w_be[l]) r_par[w_idx][l] <= w_par_new[l];
      end
   end

   // Only lanes covered by the current load are compared against their stored parity.
   assign o_Parity_Error = w_load_ok && |((w_par_cur ^ r_par[w_idx]) & w_be);

   task automatic inject_flip(input int idx, input int bit_pos);
      r_mem[idx][bit_pos] = ~r_mem[idx][bit_pos];
   endtask
`else
   assign o_Parity_Error = 1'b0;
`endif

endmodule

// File: tb/tb_arm_byte_data_memory.sv
// Scoreboard bench for arm_byte_data_memory against a byte-array reference model.
module tb_arm_byte_data_memory;

   localparam int MEM_WORDS = 64;
   localparam int MEM_BYTES = 4 * MEM_WORDS;
`ifdef DMEM_PARITY_EN
   localparam bit PARITY = 1'b1;
`else
   localparam bit PARITY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_RESET, i_Write_Enable, i_Signed;
   logic [1:0]  i_Size;
   logic [31:0] i_Address, i_Write_Data;
   logic [31:0] o_Read_Data;
   logic        o_Busy, o_Align_Fault, o_Parity_Error;

   always #5 clk = ~clk;

   arm_byte_data_memory #(.BusWidth(32), .DataMemSize(MEM_WORDS)) dut (
      .i_CLK          (clk),
      .i_RESET        (i_RESET),
      .i_Write_Enable (i_Write_Enable),
      .i_Size         (i_Size),
      .i_Signed       (i_Signed),
      .i_Address      (i_Address),
      .i_Write_Data   (i_Write_Data),
      .o_Read_Data    (o_Read_Data),
      .o_Busy         (o_Busy),
      .o_Align_Fault  (o_Align_Fault),
      .o_Parity_Error (o_Parity_Error)
   );

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        fault;
      logic        busy;
      logic        perr;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: little-endian byte array, bad-parity flags, cycles left in the sweep.
   logic [7:0] m_bytes [MEM_BYTES];
   bit         m_bad   [MEM_BYTES];
   int         busy_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.name, "_data"},  o_Read_Data,            e.data);
         check({e.name, "_fault"}, {31'b0, o_Align_Fault},  {31'b0, e.fault});
         check({e.name, "_busy"},  {31'b0, o_Busy},         {31'b0, e.busy});
         check({e.name, "_perr"},  {31'b0, o_Parity_Error}, {31'b0, e.perr});
      end
   end

   function automatic int access_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_fault(input logic [1:0] size, input int a);
      if (size == 2'b11) return 1'b1;
      if (size == 2'b01) return (a % 2) != 0;
      if (size == 2'b10) return (a % 4) != 0;
      return 1'b0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < MEM_BYTES; i++) begin
         m_bytes[i] = 8'h00;
         m_bad[i]   = 1'b0;
      end
   endtask

   // One bus cycle: drive, push the expected response, advance the model at the edge.
   task automatic op(input bit rst, input bit we, input logic [1:0] size, input bit sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input string name);
      exp_t        e;
      int          a, n;
      bit          flt;
      logic [31:0] v;
      i_RESET        = rst;
      i_Write_Enable = we;
      i_Size         = size;
      i_Signed       = sgn;
      i_Address      = addr;
      i_Write_Data   = wdata;

      a   = int'(addr % MEM_BYTES);
      n   = access_bytes(size);
      flt = is_fault(size, a);
      e.name  = name;
      e.busy  = (busy_left > 0);
      e.fault = !e.busy && flt;
      e.data  = '0;
      e.perr  = 1'b0;
      if (!e.busy && !flt) begin
         v = '0;
         for (int i = 0; i < n; i++) begin
            v = v | (32'(m_bytes[a + i]) << (8 * i));
            if (m_bad[a + i] && PARITY) e.perr = 1'b1;
         end
         if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
         if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
         e.data = v;
      end
      sb_q.push_back(e);

      @(posedge clk);
      if (rst) begin
         busy_left = MEM_WORDS;
         model_clear();
      end else if (busy_left > 0) begin
         busy_left--;
      end else if (we && !flt) begin
         for (int i = 0; i < n; i++) begin
            m_bytes[a + i] = wdata[8*i +: 8];
            m_bad[a + i]   = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      int busy_cnt;
      i_RESET = 1'b1; i_Write_Enable = 1'b0; i_Size = 2'b10; i_Signed = 1'b0;
      i_Address = '0; i_Write_Data = '0;
      model_clear();

      // Reset pulse and an explicit count of busy cycles.
      @(posedge clk); #1;
      i_RESET  = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (!o_Busy) break;
         busy_cnt++;
      end
      check("busy_len", busy_cnt, 64);
      @(posedge clk); #1;
      busy_left = 0;

      for (int k = 0; k < MEM_WORDS; k++) op(0, 0, 2'b10, 0, 32'(4 * k), '0, "clr_word");

      // Byte lanes
      op(0, 1, 2'b10, 0, 32'h10, 32'h1122_3344, "str");
      op(0, 1, 2'b00, 0, 32'h12, 32'h0000_00AB, "strb");
      op(0, 0, 2'b10, 0, 32'h10, '0, "ldr_merge");
      op(0, 0, 2'b00, 1, 32'h12, '0, "ldrb_s");
      op(0, 0, 2'b00, 0, 32'h12, '0, "ldrb_u");

      // Halfword and sign extension
      op(0, 1, 2'b01, 0, 32'h22, 32'h0000_8001, "strh");
      op(0, 0, 2'b01, 1, 32'h22, '0, "ldrh_s");
      op(0, 0, 2'b01, 0, 32'h22, '0, "ldrh_u");
      op(0, 0, 2'b10, 0, 32'h20, '0, "ldr_half");

      // Misalignment and reserved size
      op(0, 1, 2'b10, 0, 32'h05, 32'hDEAD_BEEF, "str_mis");
      op(0, 0, 2'b10, 0, 32'h04, '0, "ldr_w1");
      op(0, 0, 2'b01, 0, 32'h03, '0, "ldrh_mis");
      op(0, 0, 2'b11, 0, 32'h00, '0, "rsvd");
      op(0, 1, 2'b11, 0, 32'h08, 32'h1234_5678, "rsvd_st");
      op(0, 0, 2'b10, 0, 32'h08, '0, "ldr_w2");

      // Address wrap, then reset mid-sweep
      op(0, 1, 2'b10, 0, 32'h100, 32'hCAFE_F00D, "str_wrap");
      op(0, 0, 2'b10, 0, 32'h000, '0, "ldr_w0");
      op(0, 1, 2'b10, 0, 32'h0FC, 32'h5A5A_5A5A, "str_w63");
      op(0, 0, 2'b10, 0, 32'h0FC, '0, "ldr_w63");
      op(1, 0, 2'b10, 0, 32'h0FC, '0, "rst1");
      for (int c = 0; c < 29; c++) op(0, 1, 2'b10, 0, 32'h0FC, 32'hFFFF_FFFF, "sweep_a");
      op(1, 0, 2'b10, 0, 32'h0FC, '0, "rst2");
      for (int c = 0; c < 66; c++) op(0, 0, 2'b10, 0, 32'h0FC, '0, "sweep_b");

`ifdef DMEM_PARITY_EN
      op(0, 1, 2'b10, 0, 32'h08, 32'h0000_00FF, "par_str");
      dut.inject_flip(2, 0);
      m_bytes[8] = m_bytes[8] ^ 8'h01;
      m_bad[8]   = 1'b1;
      op(0, 0, 2'b00, 0, 32'h08, '0, "par_b8");
      op(0, 0, 2'b00, 0, 32'h09, '0, "par_b9");
      op(0, 0, 2'b10, 0, 32'h08, '0, "par_w2");
`endif

      // Randomised traffic
      for (int t = 0; t < 400; t++) begin
         int          r;
         logic [1:0]  sz;
         logic [31:0] ad;
         r  = int'($urandom_range(0, 9));
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         ad = 32'($urandom_range(0, 511));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) ad[0]   = 1'b0;
            if (sz == 2'b10) ad[1:0] = 2'b00;
         end
         op(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, "rand");
      end

      i_Write_Enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
